merge4_rr: RTL and testbench



---
 rtl/merge4_pkg.sv | 14 +
 rtl/rr_arb4.sv | 27 ++
 rtl/merge4_rr.sv | 97 +++++++++
 tb/tb_merge4_rr.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/merge4_pkg.sv
// Shared types and helpers for the 4-way merge/distribute datapath.
package merge4_pkg;

  localparam int unsigned NUM_CH = 4;

  // Channel index; same encoding as the distributor select.
  typedef logic [1:0] sel_t;

  // Next round-robin position; the 2-bit add wraps 3 -> 0.
  function automatic sel_t rr_next(sel_t x);
    return x + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr wins.
module rr_arb4
  import merge4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output sel_t              gnt,
  output logic              any
);

  sel_t idx;

  // Scan ptr, ptr+1, ptr+2, ptr+3 (mod 4) and take the first valid request.
  always_comb begin
    gnt = ptr;
    any = 1'b0;
    idx = ptr;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = ptr + sel_t'(k);
      if (!any && req[idx]) begin
        gnt = idx;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/merge4_rr.sv
// Four-to-one round-robin stream merger with a single registered output stage.
// out_sel tags each word with its source channel for downstream routing.
// Optional per-channel saturating grant counters: define MERGE4_GRANT_CNT_EN.
module merge4_rr
  import merge4_pkg::*;
#(
  parameter int unsigned width = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*width-1:0]  in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [width-1:0]         out_data,
  output sel_t                     out_sel,
  input  logic                     out_ready
`ifdef MERGE4_GRANT_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0]  grant_cnt
`endif
);

  sel_t             ptr;
  sel_t             gnt;
  logic             any;
  logic             load;
  logic             take;
  logic [width-1:0] ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*width +: width];
  end

  rr_arb4 u_arb (
    .req (in_valid),
    .ptr (ptr),
    .gnt (gnt),
    .any (any)
  );

  // Output stage can accept a word when empty or being drained this cycle.
  always_comb begin
    load     = !out_valid || out_ready;
    in_ready = 4'b0000;
    if (load && any && !rst) begin
      in_ready = 4'b0001 << gnt;
    end
    take = |in_ready;
  end

  // Pointer and output register; a simultaneous drain and fill replaces the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= ch_data[gnt];
      out_sel   <= gnt;
      ptr       <= rr_next(gnt);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MERGE4_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_CH];

  // Per-channel handshake counters that stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_ready[i] && (cnt[i] != {CNT_W{1'b1}})) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt_out
    assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end
`else
  // Counter width is meaningful only when the counters are built.
  logic [31:0] unused_cnt_w;
  assign unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_merge4_rr.sv
// Directed bench for merge4_rr; counter checks run when MERGE4_GRANT_CNT_EN is defined.
module tb_merge4_rr;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]    in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic [1:0]    out_sel;
  logic          out_ready;
`ifdef MERGE4_GRANT_CNT_EN
  logic [4*CW-1:0] grant_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  merge4_rr #(
    .width (W),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MERGE4_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    out_ready = 1'b1;

    // Reset held two cycles with all inputs valid.
    #1;
    check("rst_ready0", in_ready, 4'b0000);
    tick();
    check("rst_ready1", in_ready, 4'b0000);
    tick();
    rst      = 1'b0;
    in_valid = 4'b0000;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_sel", out_sel, 2'd0);
    check("rst_data", out_data, 8'h00);

    // Single source on channel 2.
    in_valid = 4'b0100;
    in_data  = {8'h00, 8'h5A, 8'h00, 8'h00};
    #1;
    check("single_ready", in_ready, 4'b0100);
    tick();
    in_valid = 4'b0000;
    check("single_valid", out_valid, 1'b1);
    check("single_data", out_data, 8'h5A);
    check("single_sel", out_sel, 2'd2);

    // Reset mid-operation drops the held word and returns ptr to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", out_valid, 1'b0);

    // Fairness: all four valid, expect 0,1,2,3,0,1,2,3 with no gaps.
    in_valid = 4'b1111;
    in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("fair_ready%0d", k), in_ready, 4'b0001 << (k % 4));
      tick();
      check($sformatf("fair_valid%0d", k), out_valid, 1'b1);
      check($sformatf("fair_sel%0d", k), out_sel, k % 4);
      check($sformatf("fair_data%0d", k), out_data, 8'h10 + (k % 4));
    end

    // Backpressure: word from channel 3 held for 5 cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_ready%0d", k), in_ready, 4'b0000);
      tick();
      check($sformatf("bp_valid%0d", k), out_valid, 1'b1);
      check($sformatf("bp_sel%0d", k), out_sel, 2'd3);
      check($sformatf("bp_data%0d", k), out_data, 8'h13);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 4'b0001);
    tick();
    check("bp_release_valid", out_valid, 1'b1);
    check("bp_release_sel", out_sel, 2'd0);
    check("bp_release_data", out_data, 8'h10);

    // Pointer skip and wrap: grant 3 (ptr->0), then 1 and 3 valid.
    in_valid = 4'b1000;
    #1;
    check("skip_ready_a", in_ready, 4'b1000);
    tick();
    check("skip_sel_a", out_sel, 2'd3);
    in_valid = 4'b1010;
    #1;
    check("skip_ready_b", in_ready, 4'b0010);
    tick();
    check("skip_sel_b", out_sel, 2'd1);
    check("skip_data_b", out_data, 8'h11);
    #1;
    check("skip_ready_c", in_ready, 4'b1000);
    tick();
    check("skip_sel_c", out_sel, 2'd3);
    in_valid = 4'b1111;
    #1;
    check("wrap_ready", in_ready, 4'b0001);

    // Drain with no new input: valid drops, data and sel hold.
    in_valid = 4'b0000;
    tick();
    check("drain_valid", out_valid, 1'b0);
    check("drain_sel", out_sel, 2'd3);
    check("drain_data", out_data, 8'h13);

`ifdef MERGE4_GRANT_CNT_EN
    // Five handshakes on channel 0 saturate a 2-bit counter at 3.
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      tick();
    end
    in_valid = 4'b0000;
    check("cnt_sat", grant_cnt, 8'h03);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("cnt_clear", grant_cnt, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
